pool_result_writer: RTL and testbench

- Stage directly downstream of the ReLU/max-pool lane array.
- Captures each pooled pixel (PE_Num channel lanes in parallel, strobed by the pool stage's dout_st) into a small wide FIFO.
- Serialises the lanes into single-word writes to the feature-map buffer, generating channel-major addresses.
- Signals end-of-pass when all pooled pixels of the map are written.

---
 rtl/pool_writer_pkg.sv | 21 ++
 rtl/pool_word_fifo.sv | 54 +++++
 rtl/pool_result_writer.sv | 159 +++++++++++++++
 tb/tb_pool_result_writer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_writer_pkg.sv
// Shared types and helpers for the pooled-pixel result writer.
// State encoding, pixel-count width and a pointer-width helper.
package pool_writer_pkg;

    localparam int NPIX_W = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_RUN,
        S_DONE
    } state_t;

    function automatic int clog2c(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/pool_word_fifo.sv
// Wide-word synchronous FIFO holding whole pooled pixels.
// Push while full is accepted only when a pop happens in the same cycle.
module pool_word_fifo
    import pool_writer_pkg::*;
#(
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = clog2c(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pool_result_writer.sv
// Buffers pooled pixels and serialises their channel lanes into
// single-word feature-map writes at channel-major addresses.
module pool_result_writer
    import pool_writer_pkg::*;
#(
    parameter int dwidth     = 16,
    parameter int PE_Num     = 8,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [4:0]               featmap_size,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic                     din_valid,
    input  logic [PE_Num*dwidth-1:0] din,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [dwidth-1:0]        wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);

    localparam int FW = PE_Num * dwidth;
    localparam int LW = clog2c(PE_Num);

    state_t              state;
    logic [4:0]          size_q;
    logic [ADDR_W-1:0]   base_q;
    logic [NPIX_W-1:0]   npix;
    logic [NPIX_W-1:0]   acc;
    logic [NPIX_W-1:0]   pix;
    logic [FW-1:0]       word;
    logic [LW-1:0]       lane;
    logic                active;

    logic [FW-1:0]       head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [dwidth-1:0]   word_lanes [PE_Num];

    logic                run;
    logic                last_lane;
    logic                pop;
    logic                push_req;
    logic                push;
    logic                drop;
    logic                last_write;
    logic [LW-1:0]       lane_nx;
    logic [NPIX_W-1:0]   pix_nx;

    for (genvar g = 0; g < PE_Num; g++) begin : g_lanes
        assign word_lanes[g] = word[g*dwidth +: dwidth];
    end

    assign run        = (state == S_RUN);
    assign last_lane  = active && (lane == LW'(PE_Num - 1));
    assign pop        = run && (!active || last_lane) && !fifo_empty;
    assign push_req   = run && din_valid && (acc < npix);
    assign push       = push_req && (!fifo_full || pop);
    assign drop       = push_req && !push;
    assign last_write = last_lane && (pix == npix - 1'b1);
    assign lane_nx    = LW'(lane + 1'b1);
    assign pix_nx     = last_lane ? pix + 1'b1 : pix;

    pool_word_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (din),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            size_q   <= '0;
            base_q   <= '0;
            npix     <= '0;
            acc      <= '0;
            pix      <= '0;
            word     <= '0;
            lane     <= '0;
            active   <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        size_q   <= featmap_size;
                        base_q   <= base_addr;
                        acc      <= '0;
                        pix      <= '0;
                        active   <= 1'b0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    npix <= NPIX_W'(size_q) * NPIX_W'(size_q);
                    if (size_q == '0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (push) acc <= acc + 1'b1;
                    if (drop) overflow <= 1'b1;
                    // Lane 0 goes out in the same edge the word is loaded.
                    if (pop) begin
                        word    <= head;
                        lane    <= '0;
                        active  <= 1'b1;
                        pix     <= pix_nx;
                        wr_en   <= 1'b1;
                        wr_data <= head[dwidth-1:0];
                        wr_addr <= base_q + ADDR_W'(pix_nx);
                    end else if (active && !last_lane) begin
                        lane    <= lane_nx;
                        wr_en   <= 1'b1;
                        wr_data <= word_lanes[lane_nx];
                        wr_addr <= wr_addr + ADDR_W'(npix);
                    end else if (last_lane) begin
                        active <= 1'b0;
                        pix    <= pix + 1'b1;
                    end
                    if (last_write) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_result_writer.sv
// Randomised bench for pool_result_writer against a pixel-timing model.
// Also pins the model with hand-computed addresses and latencies.
module tb_pool_result_writer;

    localparam int DW  = 16;
    localparam int PE  = 8;
    localparam int AW  = 12;
    localparam int FD  = 4;
    localparam int INF = 1 << 30;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [4:0]        featmap_size;
    logic [AW-1:0]     base_addr;
    logic              din_valid;
    logic [PE*DW-1:0]  din;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              busy;
    logic              done;
    logic              overflow;

    pool_result_writer #(
        .dwidth     (DW),
        .PE_Num     (PE),
        .ADDR_W     (AW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .featmap_size (featmap_size),
        .base_addr    (base_addr),
        .din_valid    (din_valid),
        .din          (din),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    // Model: each accepted pixel k is popped at edge p[k]; its lane i
    // is written in cycle p[k]+1+i.
    bit               m_act = 0;
    bit               m_prev_ovf = 0;
    int               m_s, m_npix, m_base, m_acc;
    int               m_done = INF;
    int               m_ovf = INF;
    int               m_p [1024];
    logic [PE*DW-1:0] m_pix [1024];

    function automatic void model_start(int c, int size, int base);
        if (m_act && c <= m_done) return;
        m_prev_ovf = m_act && (c >= m_ovf);
        m_act  = 1;
        m_s    = c;
        m_npix = size * size;
        m_base = base;
        m_acc  = 0;
        m_ovf  = INF;
        m_done = (m_npix == 0) ? c + 2 : INF;
    endfunction

    function automatic void model_valid(int c, logic [PE*DW-1:0] d);
        int occ;
        bit pop_now;
        if (!m_act || c < m_s + 2 || m_acc >= m_npix) return;
        occ = 0;
        pop_now = 0;
        for (int k = 0; k < m_acc; k++) begin
            if (m_p[k] >= c) occ++;
            if (m_p[k] == c) pop_now = 1;
        end
        if (occ < FD || pop_now) begin
            m_p[m_acc] = (m_acc == 0) ? c + 1
                       : ((c + 1 > m_p[m_acc-1] + PE) ? c + 1
                                                      : m_p[m_acc-1] + PE);
            m_pix[m_acc] = d;
            m_acc++;
            if (m_acc == m_npix) m_done = m_p[m_acc-1] + PE + 1;
        end else if (m_ovf == INF) begin
            m_ovf = c + 1;
        end
    endfunction

    typedef struct { int c; int a; int d; } wr_t;
    wr_t log_q [$];
    int  last_done = -1;

    always @(negedge clk) begin : cmp
        bit e_en;
        int e_a, e_d, ln;
        bit e_ovf;
        if (!rst_n) begin
            chk("rst_wr_en", {31'b0, wr_en}, 0);
            chk("rst_wr_addr", {20'b0, wr_addr}, 0);
            chk("rst_wr_data", {16'b0, wr_data}, 0);
            chk("rst_busy", {31'b0, busy}, 0);
            chk("rst_done", {31'b0, done}, 0);
            chk("rst_overflow", {31'b0, overflow}, 0);
        end else begin
            e_en = 0; e_a = 0; e_d = 0;
            if (m_act) begin
                for (int k = 0; k < m_acc; k++) begin
                    if (cyc >= m_p[k] + 1 && cyc <= m_p[k] + PE) begin
                        ln   = cyc - m_p[k] - 1;
                        e_en = 1;
                        e_a  = (m_base + ln * m_npix + k) % 4096;
                        e_d  = int'(m_pix[k][ln*DW +: DW]);
                    end
                end
            end
            e_ovf = m_act && ((cyc <= m_s) ? m_prev_ovf : (cyc >= m_ovf));
            chk("wr_en", {31'b0, wr_en}, {31'b0, e_en});
            if (e_en) begin
                chk("wr_addr", {20'b0, wr_addr}, e_a);
                chk("wr_data", {16'b0, wr_data}, e_d);
            end
            chk("busy", {31'b0, busy},
                {31'b0, m_act && cyc >= m_s + 1 && cyc <= m_done});
            chk("done", {31'b0, done}, {31'b0, m_act && cyc == m_done});
            chk("overflow", {31'b0, overflow}, {31'b0, e_ovf});
            if (wr_en === 1'b1) log_q.push_back('{cyc, int'(wr_addr), int'(wr_data)});
            if (done === 1'b1) last_done = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int size, input int base);
        start = 1'b1;
        featmap_size = 5'(size);
        base_addr = AW'(base);
        model_start(cyc, size, base);
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [PE*DW-1:0] d);
        din_valid = 1'b1;
        din = d;
        model_valid(cyc, d);
        tick();
        din_valid = 1'b0;
    endtask

    function automatic logic [PE*DW-1:0] rnd_pix();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic feed(input int gap_max, input int budget);
        int b = 0;
        while (m_acc < m_npix && b < budget) begin
            if ($urandom_range(0, gap_max) == 0) send(rnd_pix());
            else tick();
            b++;
        end
        if (m_acc < m_npix) chk("feed_timeout", 1, 0);
    endtask

    task automatic wait_pass(input int budget);
        int b = 0;
        while (!(m_act && cyc > m_done) && b < budget) begin
            tick();
            b++;
        end
        if (b >= budget) chk("pass_timeout", 1, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0]      lv [8];
        logic [PE*DW-1:0] w;
        int li, vc, sc, n;

        rst_n = 1'b0;
        start = 1'b0;
        featmap_size = '0;
        base_addr = '0;
        din_valid = 1'b0;
        din = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Basic pass with a known first pixel.
        lv = '{16'd7, 16'hFFFF, 16'd5, 16'hFFFD,
               16'h0100, 16'h8000, 16'h7FFF, 16'h0042};
        for (int i = 0; i < PE; i++) w[i*DW +: DW] = lv[i];
        li = log_q.size();
        do_start(5, 'h100);
        tick();
        vc = cyc;
        send(w);
        for (int i = 1; i < 25; i++) begin
            repeat (9) tick();
            if (i == 3) do_start(7, 'h222);
            else tick();
            send(rnd_pix());
        end
        send(rnd_pix());
        wait_pass(400);
        tick();
        chk("basic_count", log_q.size() - li, 200);
        chk("basic_a0", log_q[li].a, 'h100);
        chk("basic_a1", log_q[li+1].a, 'h119);
        chk("basic_a2", log_q[li+2].a, 'h132);
        chk("basic_a3", log_q[li+3].a, 'h14B);
        chk("basic_alast", log_q[li+199].a, 'h1C7);
        chk("basic_done_gap", last_done - log_q[li+199].c, 1);
        chk("basic_latency", log_q[li].c - vc, 2);
        for (int i = 0; i < PE; i++)
            chk("lane_data", log_q[li+i].d, int'(lv[i]));
        chk("basic_busy_low", {31'b0, busy}, 0);
        chk("basic_no_ovf", {31'b0, overflow}, 0);

        // Burst of six pixels into a four-deep FIFO.
        li = log_q.size();
        do_start(3, 'h040);
        tick();
        chk("ovf_before", {31'b0, overflow}, 0);
        for (int i = 0; i < 6; i++) send(rnd_pix());
        chk("ovf_after", {31'b0, overflow}, 1);
        repeat (40) tick();
        n = log_q.size() - li;
        chk("ovf_writes", n, 40);
        if (n >= 40) chk("ovf_no_gaps", log_q[li+39].c - log_q[li].c, 39);
        feed(8, 400);
        wait_pass(200);

        // Empty map.
        li = log_q.size();
        sc = cyc;
        do_start(0, 'h300);
        repeat (4) tick();
        chk("empty_done", last_done - sc, 2);
        chk("empty_writes", log_q.size() - li, 0);

        // Address wrap.
        li = log_q.size();
        do_start(14, 'hFF0);
        feed(10, 6000);
        wait_pass(200);
        tick();
        chk("wrap_count", log_q.size() - li, 1568);
        chk("wrap_a0", log_q[li].a, 'hFF0);
        chk("wrap_lane1", log_q[li+1].a, 'h0B4);

        // Random passes with varying density.
        for (int r = 0; r < 4; r++) begin
            do_start($urandom_range(1, 5), $urandom_range(0, 4095));
            feed($urandom_range(0, 9), 2000);
            wait_pass(300);
            repeat ($urandom_range(0, 3)) tick();
        end

        // Reset in the middle of a pass, then a clean pass.
        do_start(4, 'h500);
        tick();
        send(rnd_pix());
        send(rnd_pix());
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        m_act = 0;
        #1;
        chk("midrst_wr_en", {31'b0, wr_en}, 0);
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_addr", {20'b0, wr_addr}, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        li = log_q.size();
        do_start(2, 'h010);
        feed(5, 400);
        wait_pass(200);
        tick();
        chk("post_rst_count", log_q.size() - li, 32);
        chk("post_rst_a1", log_q[li+1].a, 'h014);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
